// File: rtl/afifo_pop_stream_if.sv
// Purpose: registered valid/ready word stream leaving the FIFO pop stage.
// Latency: none, this is a bundle of wires.
// Backpressure: the slave holds m_ready low to stall; the master keeps m_data/m_valid stable.
interface afifo_pop_stream_if #(
    parameter int DATA_WIDTH = 18
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/afifo_pop_stream.sv
// Purpose: drain the async FIFO pop side into a registered valid/ready stream via a credit-checked skid buffer.
// Latency: fifo_pop in cycle 0 -> m_valid in cycle RD_LAT+1; one word/cycle sustained.
// Backpressure: pops stop when skid + in-flight words would exceed SKID_DEPTH; optional underrun counter under AFIFO_POP_STREAM_ERRCNT_EN.
module afifo_pop_stream #(
    parameter int DATA_WIDTH = 18,
    parameter int RD_LAT     = 1,
    parameter int SKID_DEPTH = RD_LAT + 1
) (
    input  logic                  clock1,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    input  logic                  fifo_underrun,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_pop,
    input  logic                  flush,
    output logic [15:0]           err_cnt,
    afifo_pop_stream_if.master    m_stream
);
    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int OW = $clog2(SKID_DEPTH + 1);
    localparam int CW = OW + 2;
    localparam logic [PW-1:0] PTR_LAST = PW'(SKID_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [OW-1:0]         occ;
    logic [RD_LAT-1:0]     inflight;
    logic [CW-1:0]         infl_cnt;
    logic [1:0]            drain_cnt;
    logic                  pop_q;
    logic                  run;
    logic                  hs, wr_en, rd_en, credit_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign m_stream.m_valid = (occ != '0);
    assign m_stream.m_data  = skid_mem[rd_ptr];

    // flush wins over both the returning word and the consumer handshake
    assign hs    = m_stream.m_valid && m_stream.m_ready;
    assign wr_en = inflight[RD_LAT-1] && !flush;
    assign rd_en = hs && !flush;

    // number of words popped but not yet landed in the skid buffer
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            infl_cnt = infl_cnt + CW'(inflight[i]);
        end
    end

    // a slot is guaranteed for a new pop if buffered + in-flight - leaving < depth
    assign credit_ok = (CW'(occ) + infl_cnt) < (CW'(SKID_DEPTH) + CW'(hs));

    // pop decision and next state; run keeps fifo_pop low until the first edge after reset
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        if (run && !flush && (state != DRAIN) && !fifo_empty &&
            !(pop_q && fifo_almost_empty) && credit_ok) begin
            fifo_pop = 1'b1;
        end
        case (state)
            IDLE:    if (fifo_pop) state_nxt = ACTIVE;
            ACTIVE:  if ((occ == '0) && (inflight == '0) && !fifo_pop) state_nxt = IDLE;
            DRAIN:   if (!flush && (drain_cnt <= 2'd1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = DRAIN;
    end

    // state register plus the post-flush wait that covers words still returning from the FIFO
    always_ff @(posedge clock1 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            drain_cnt <= 2'd0;
            run       <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            pop_q <= fifo_pop;
            if (flush) begin
                drain_cnt <= 2'(RD_LAT);
            end else if ((state == DRAIN) && (drain_cnt != 2'd0)) begin
                drain_cnt <= drain_cnt - 2'd1;
            end
        end
    end

    // skid buffer, pointers, occupancy and in-flight tracking; flush discards everything
    always_ff @(posedge clock1 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) skid_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            inflight <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            inflight <= '0;
        end else begin
            inflight <= RD_LAT'({inflight, fifo_pop});
            if (wr_en) begin
                skid_mem[wr_ptr] <= fifo_dout;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_en && !rd_en) begin
                occ <= occ + 1'b1;
            end else if (!wr_en && rd_en) begin
                occ <= occ - 1'b1;
            end
        end
    end

`ifdef AFIFO_POP_STREAM_ERRCNT_EN
    // saturating count of cycles with the FIFO reporting underrun
    always_ff @(posedge clock1 or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= 16'd0;
        end else if (fifo_underrun && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    logic unused_underrun;
    assign unused_underrun = fifo_underrun;
    assign err_cnt         = 16'd0;
`endif
endmodule

// File: tb/tb_afifo_pop_stream.sv
module tb_afifo_pop_stream;
    localparam int DW = 18;
    localparam int RD_LAT = 1;

    logic          clock1 = 1'b0;
    logic          reset_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_almost_empty = 1'b0;
    logic          fifo_underrun = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_pop;
    logic          flush = 1'b0;
    logic [15:0]   err_cnt;

    afifo_pop_stream_if #(.DATA_WIDTH(DW)) m_if ();

    afifo_pop_stream #(.DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
        .clock1            (clock1),
        .reset_n           (reset_n),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_underrun     (fifo_underrun),
        .fifo_dout         (fifo_dout),
        .fifo_pop          (fifo_pop),
        .flush             (flush),
        .err_cnt           (err_cnt),
        .m_stream          (m_if)
    );

    always #5 clock1 = ~clock1;

    int checks = 0;
    int errors = 0;
    int model_pops = 0;
    int delivered = 0;
    int pops_seen = 0;
    logic [DW-1:0] fq [$];
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clock1);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) cyc();
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // FIFO model: flags registered from the previous cycle's fill, read data one cycle after POP
    always @(posedge clock1) begin
        fifo_empty        <= (fq.size() == 0);
        fifo_almost_empty <= (fq.size() == 1);
        if (fifo_pop) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty actual=pop required=no_pop");
            end else begin
                fifo_dout <= fq.pop_front();
                model_pops++;
            end
        end
    end

    // scoreboard monitor: every accepted stream word must match the next expected word
    always @(negedge clock1) begin
        if (fifo_pop) pops_seen++;
        if (reset_n && m_if.m_valid && m_if.m_ready && !flush) begin
            checks++;
            delivered++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra actual=%0h required=none", m_if.m_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (m_if.m_data !== e) begin
                    errors++;
                    $display("FAIL stream_data actual=%0h required=%0h", m_if.m_data, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int p0, d0, mp0;
        m_if.m_ready = 1'b0;
        cyc(); cyc();
        check("rst_m_valid", 32'(m_if.m_valid), 32'd0);
        check("rst_m_data", 32'(m_if.m_data), 32'd0);
        check("rst_fifo_pop", 32'(fifo_pop), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        reset_n = 1'b1;
        m_if.m_ready = 1'b1;
        cyc(); cyc();

        // single word
        p0 = pops_seen;
        push_word(18'h2A5A5);
        cyc();
        check("single_pop_c0", 32'(fifo_pop), 32'd1);
        cyc();
        check("single_pop_c1", 32'(fifo_pop), 32'd0);
        check("single_valid_c1", 32'(m_if.m_valid), 32'd0);
        cyc();
        check("single_valid_c2", 32'(m_if.m_valid), 32'd1);
        check("single_data_c2", 32'(m_if.m_data), 32'h2A5A5);
        repeat (5) cyc();
        check("single_pop_count", 32'(pops_seen - p0), 32'd1);
        wait_empty("single");

        // 64-word burst at full rate
        d0 = delivered;
        for (int i = 0; i < 64; i++) push_word(DW'(32'h100 + i));
        cyc();
        for (int i = 0; i < 64; i++) begin
            check("burst_pop", 32'(fifo_pop), 32'd1);
            cyc();
        end
        check("burst_pop_after_last", 32'(fifo_pop), 32'd0);
        cyc(); cyc();
        check("burst_delivered", 32'(delivered - d0), 32'd64);
        wait_empty("burst");

        // backpressure mid-burst
        d0 = delivered; mp0 = model_pops;
        for (int i = 0; i < 20; i++) push_word(DW'(32'h200 + i));
        cyc();
        repeat (5) cyc();
        m_if.m_ready = 1'b0;
        repeat (10) cyc();
        check("bp_outstanding", 32'((model_pops - mp0) - (delivered - d0)), 32'd2);
        check("bp_pop_stalled", 32'(fifo_pop), 32'd0);
        check("bp_valid_held", 32'(m_if.m_valid), 32'd1);
        check("bp_data_held", 32'(m_if.m_data), 32'h203);
        m_if.m_ready = 1'b1;
        wait_empty("bp");
        check("bp_delivered", 32'(delivered - d0), 32'd20);

        // flush with one word buffered and one in flight
        d0 = delivered; mp0 = model_pops;
        for (int i = 0; i < 10; i++) push_word(DW'(32'h300 + i));
        cyc(); cyc(); cyc(); cyc(); cyc();
        check("flush_head", 32'(m_if.m_data), 32'h302);
        flush = 1'b1;
        #1;
        check("flush_pop_c0", 32'(fifo_pop), 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        cyc();
        flush = 1'b0;
        #1;
        check("flush_valid_c1", 32'(m_if.m_valid), 32'd0);
        check("flush_pop_c1", 32'(fifo_pop), 32'd0);
        check("flush_discarded", 32'((model_pops - mp0) - (delivered - d0)), 32'd2);
        cyc();
        check("flush_restart_pop", 32'(fifo_pop), 32'd1);
        wait_empty("flush");
        check("flush_delivered", 32'(delivered - d0), 32'd8);

        // asynchronous reset mid-burst
        d0 = delivered;
        for (int i = 0; i < 10; i++) push_word(DW'(32'h400 + i));
        cyc(); cyc(); cyc(); cyc();
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(m_if.m_valid), 32'd0);
        check("arst_data", 32'(m_if.m_data), 32'd0);
        check("arst_pop", 32'(fifo_pop), 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
        check("arst_resume_pop", 32'(fifo_pop), 32'd1);
        wait_empty("arst");
        check("arst_delivered", 32'(delivered - d0), 32'd8);

        // underrun counter
        fifo_underrun = 1'b1;
        cyc(); cyc(); cyc();
        fifo_underrun = 1'b0;
        cyc();
`ifdef AFIFO_POP_STREAM_ERRCNT_EN
        check("err_cnt", 32'(err_cnt), 32'd3);
`else
        check("err_cnt", 32'(err_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
